// File: rtl/cnn_ram_tx_packer.sv
// Dumps a bit-serial 1-bit RAM image to the UART transmitter, packing bits LSB-first into bytes.
// Each bit costs one RAM read cycle plus one capture cycle; one byte is outstanding at a time.
module cnn_ram_tx_packer #(
  parameter int ADDR_W   = 10,
  parameter int NUM_BITS = 784
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strt,
  input  logic              abort,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_dout,
  output logic              trmt,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              bsy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_BITS - 1);
  localparam logic [ADDR_W:0] END_IDX  = (ADDR_W+1)'(NUM_BITS);

  state_t          state;
  logic [ADDR_W:0] bit_idx;
  logic [2:0]      bit_pos;
  logic [7:0]      byte_reg;
  logic [7:0]      byte_nxt;

  // Byte including the bit being captured this cycle, so a completed byte is sent without an extra cycle.
  always_comb begin
    byte_nxt          = byte_reg;
    byte_nxt[bit_pos] = ram_dout;
  end

  assign ram_addr = bit_idx[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bit_idx  <= '0;
      bit_pos  <= '0;
      byte_reg <= '0;
      tx_data  <= '0;
      trmt     <= 1'b0;
      bsy      <= 1'b0;
      done     <= 1'b0;
    end else begin
      trmt <= 1'b0;
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        bsy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (strt) begin
              state    <= S_RD;
              bsy      <= 1'b1;
              bit_idx  <= '0;
              bit_pos  <= '0;
              byte_reg <= '0;
            end
          end
          S_RD: state <= S_CAP;
          S_CAP: begin
            byte_reg <= byte_nxt;
            bit_idx  <= bit_idx + 1'b1;
            bit_pos  <= bit_pos + 3'd1;
            if (bit_pos == 3'd7 || bit_idx == LAST_IDX) begin
              tx_data <= byte_nxt;
              trmt    <= 1'b1;
              state   <= S_SEND;
            end else begin
              state <= S_RD;
            end
          end
          S_SEND: state <= S_WAIT;
          S_WAIT: begin
            if (tx_done) begin
              byte_reg <= '0;
              bit_pos  <= '0;
              if (bit_idx == END_IDX) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_RD;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            bsy   <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            bsy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_ram_tx_packer.sv
// Bench for cnn_ram_tx_packer: three instances (16, 12, 784 bits) checked against bytes packed
// directly from the bench's RAM images.
module tb_cnn_ram_tx_packer;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]    strt_v, abort_v, tx_done_v, trmt_v, bsy_v, done_v;
  logic [AW-1:0] addr_v [3];
  logic [7:0]    txd_v  [3];
  logic          mem    [3][1024];

  int vectors = 0;
  int miscompares = 0;
  int tcnt, dcnt, maxa;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NB = (g == 0) ? 16 : ((g == 1) ? 12 : 784);
    logic rd_q;
    always @(posedge clk) rd_q <= mem[g][addr_v[g]];
    cnn_ram_tx_packer #(.ADDR_W(AW), .NUM_BITS(NB)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .strt     (strt_v[g]),
      .abort    (abort_v[g]),
      .ram_addr (addr_v[g]),
      .ram_dout (rd_q),
      .trmt     (trmt_v[g]),
      .tx_data  (txd_v[g]),
      .tx_done  (tx_done_v[g]),
      .bsy      (bsy_v[g]),
      .done     (done_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: byte b is RAM bits 8b..8b+7, LSB first, bits past the image end read as 0.
  function automatic logic [7:0] exp_byte(input int s, input int nb, input int b);
    logic [7:0] v = '0;
    for (int j = 0; j < 8; j++)
      if (8*b + j < nb) v[j] = mem[s][8*b + j];
    return v;
  endfunction

  task automatic tick(input int s);
    @(posedge clk);
    #1;
    if (trmt_v[s]) tcnt++;
    if (done_v[s]) dcnt++;
  endtask

  task automatic serve_byte(input int s, input int nb, input int b,
                            input bit first, input bit hold, input bit poke);
    int n = 0;
    bit seen = 0;
    int bad = 0;
    logic [7:0] lat_d;
    logic [AW-1:0] lat_a;
    while (!seen && n < 40) begin
      tick(s);
      n++;
      if (trmt_v[s]) seen = 1;
      else if (int'(addr_v[s]) > maxa) maxa = int'(addr_v[s]);
      strt_v[s] = poke && (n == 3);
    end
    strt_v[s] = 1'b0;
    check($sformatf("trmt_seen[%0d]", b), 32'(seen), 32'd1);
    if (!seen) return;
    if (first) check("first_trmt_latency", 32'(n), 32'd16);
    check($sformatf("tx_data[%0d]", b), 32'(txd_v[s]), 32'(exp_byte(s, nb, b)));
    tick(s);
    check("trmt_one_cycle", 32'(trmt_v[s]), 32'd0);
    if (hold) begin
      lat_d = txd_v[s];
      lat_a = addr_v[s];
      repeat (50) begin
        tick(s);
        if (trmt_v[s] || txd_v[s] !== lat_d || addr_v[s] !== lat_a) bad++;
      end
      check("hold_stable", 32'(bad), 32'd0);
    end
    tx_done_v[s] = 1'b1;
    tick(s);
    tx_done_v[s] = 1'b0;
  endtask

  task automatic run_dump(input int s, input int nb, input bit hold, input bit poke);
    int nbytes = (nb + 7) / 8;
    tcnt = 0; dcnt = 0; maxa = 0;
    strt_v[s] = 1'b1;
    tick(s);
    strt_v[s] = 1'b0;
    check("start_addr", 32'(addr_v[s]), 32'd0);
    check("start_bsy", 32'(bsy_v[s]), 32'd1);
    for (int b = 0; b < nbytes; b++)
      serve_byte(s, nb, b, b == 0, hold && b == 0, poke && b == 1);
    check("done_pulse", 32'({done_v[s], bsy_v[s]}), 32'b11);
    tick(s);
    check("after_done", 32'({done_v[s], bsy_v[s]}), 32'b00);
    repeat (3) tick(s);
    check("trmt_count", 32'(tcnt), 32'(nbytes));
    check("done_count", 32'(dcnt), 32'd1);
    check("max_addr", 32'(maxa), 32'(nb - 1));
  endtask

  initial begin
    logic [7:0] v0 = 8'hA5;
    logic [7:0] v1 = 8'h3C;
    int n;
    rst_n = 1'b0;
    strt_v = '0; abort_v = '0; tx_done_v = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[0][i] = 1'b0;
      mem[1][i] = 1'b1;
      mem[2][i] = 1'($urandom_range(0, 1));
    end
    for (int j = 0; j < 8; j++) begin
      mem[0][j]     = v0[j];
      mem[0][8 + j] = v1[j];
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", 32'(addr_v[0]), 32'd0);
    check("rst_txd", 32'(txd_v[0]), 32'd0);
    check("rst_ctl", 32'({trmt_v[0], bsy_v[0], done_v[0]}), 32'd0);
    rst_n = 1'b1;
    tick(0);

    // 16-bit dump with latency and withheld tx_done
    run_dump(0, 16, 1'b1, 1'b0);
    // 12-bit all-ones dump, strt poked while busy
    run_dump(1, 12, 1'b0, 1'b1);

    // Abort in WAIT, late tx_done ignored, then clean restart
    tcnt = 0; dcnt = 0;
    strt_v[0] = 1'b1;
    tick(0);
    strt_v[0] = 1'b0;
    n = 0;
    while (!trmt_v[0] && n < 40) begin tick(0); n++; end
    check("abort_first_trmt", 32'(trmt_v[0]), 32'd1);
    tick(0);
    abort_v[0] = 1'b1;
    tick(0);
    abort_v[0] = 1'b0;
    check("abort_idle", 32'({bsy_v[0], trmt_v[0], done_v[0]}), 32'd0);
    tx_done_v[0] = 1'b1;
    tick(0);
    tx_done_v[0] = 1'b0;
    repeat (5) tick(0);
    check("abort_stays_idle", 32'(bsy_v[0]), 32'd0);
    check("abort_no_done", 32'(dcnt), 32'd0);
    check("abort_trmt_count", 32'(tcnt), 32'd1);
    run_dump(0, 16, 1'b0, 1'b0);

    // Asynchronous reset during the capture of byte 3 of the 784-bit image
    strt_v[2] = 1'b1;
    tick(2);
    strt_v[2] = 1'b0;
    for (int b = 0; b < 3; b++) serve_byte(2, 784, b, b == 0, 1'b0, 1'b0);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_addr", 32'(addr_v[2]), 32'd0);
    check("midrst_txd", 32'(txd_v[2]), 32'd0);
    check("midrst_ctl", 32'({trmt_v[2], bsy_v[2], done_v[2]}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    run_dump(2, 784, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
